player_move_ctrl: RTL and testbench
===================================

# player_move_ctrl

Movement sequencer for the maze game's player sprite. Debounces the four direction buttons, arbitrates them to a single direction, and issues one-cycle step strobes at a fixed repeat rate. With vblank sync compiled in, steps are aligned to vertical blanking so the sprite never moves mid-frame. It sits between the board buttons and the player position/sprite block, replacing the free-running move clock.

## Interface
Parameters:
- `DB_COUNT`, 250000: consecutive stable cycles required before a debounced button changes (10 ms at 25 MHz); range 2..2^20-1.
- `STEP_DIV`, 100000: cycles between repeated steps while a button is held; range 2..2^20-1.

Ports:
- `clk`  in  1  pixel/system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `btn_left`, `btn_right`, `btn_up`, `btn_down`  in  1 each  raw, pre-synchronized buttons.
- `vblank`  in  1  level, high during the vertical blanking interval.
- `move_step`  out  1  one-cycle pulse: move sprite one pixel in `move_dir`.
- `move_dir`  out  2  00 left, 01 right, 10 up, 11 down.
- `moving`  out  1  high while any debounced direction is held, i.e. state != IDLE.

## Operation
- Debounce, per button:
  - 20-bit counter resets to 0 whenever the raw level equals the debounced level.
  - Otherwise it increments. When it reaches `DB_COUNT-1`, the debounced level flips and the counter clears.
- Arbitration is sticky:
  - If the currently granted direction is still held, keep it.
  - Otherwise use fixed priority left > right > up > down.
- FSM states: IDLE, ARM, WAIT_VB, STEP.
  - IDLE: `moving`=0, step timer held at 0. On any debounced button, arbitrate, latch `move_dir`, then go to WAIT_VB. The first step is issued at the next vblank, with no `STEP_DIV` wait.
  - WAIT_VB: if `vblank`=1, go to STEP. If all buttons are released, go to IDLE with no step.
  - STEP: `move_step`=1 for exactly this cycle. Then re-arbitrate, update `move_dir` for the next step, clear the timer, and go to ARM. If no button is held, go to IDLE instead.
  - ARM: timer increments each cycle. At `STEP_DIV-1`, go to WAIT_VB. If all buttons are released, go to IDLE and clear the timer.
- `move_dir` changes only on IDLE exit or in the STEP cycle. It is never changed while `move_step`=1.
- Opposite buttons held together: priority decides, with no cancellation. For example, left+right with nothing granted yields left.

## Timing
- Reset values: `move_step`=0, `move_dir`=00, `moving`=0; FSM IDLE; all counters 0; debounced levels 0.
- Reset asserted mid-operation takes effect on the next edge: no further `move_step`, state to IDLE. Debouncers restart from 0.
- All outputs are registered.
- Press latency: debounced level rises `DB_COUNT` cycles after the raw edge. `moving` rises 1 cycle after that.
- First `move_step`: the first cycle after entering WAIT_VB with `vblank`=1, i.e. 1 cycle after WAIT_VB entry if already in vblank.
- Repeat period (macro off): exactly `STEP_DIV`+2 cycles between pulses (STEP, ARM x`STEP_DIV`, WAIT_VB).
- Repeat period (macro on): as above, plus the wait for vblank.
- Release: `moving` falls 1 cycle after the debounced release. A pending step is dropped.

## Configuration
- `MOVE_VBLANK_SYNC_EN`
  - Defined: WAIT_VB gates on `vblank` as described.
  - Undefined: WAIT_VB treats `vblank` as constantly 1, so each step fires 1 cycle after the timer expires (or 1 cycle after IDLE exit). The `vblank` port stays present but is ignored.

## Structure
- Shared header `game_defs.vh`:
  - Direction codes DIR_LEFT/RIGHT/UP/DOWN (00/01/10/11).
  - FSM state encodings.
  - The player block decodes `move_dir` with the same direction codes.
- Sub-module `btn_debounce` (parameter `DB_COUNT`), instantiated four times.
- FSM, arbiter and step timer live in `player_move_ctrl`.

## Test plan
Bench parameters: `DB_COUNT`=4, `STEP_DIV`=8, macro defined.
- Raw `btn_left` bouncing 1-0-1 at 2-cycle spacing, then held -> debounced rise only after 4 stable cycles; exactly one IDLE exit; `move_dir`=00.
- Hold `btn_right` with `vblank`=1 constant -> first `move_step` 1 cycle after WAIT_VB entry, then pulses every 10 cycles, `move_dir`=01 throughout.
- Hold `btn_up` with `vblank` pulsing high 2 of every 50 cycles -> every `move_step` coincides with `vblank`=1; exactly one pulse per vblank window.
- Hold `btn_down`, then add `btn_left` -> `move_dir` stays 11 (sticky). Release down -> next STEP switches to 00.
- Release all buttons while in WAIT_VB -> no `move_step`; `moving`=0 next cycle; state IDLE.
- Assert `rst` 1 cycle during ARM with a button held -> next edge: outputs 00/0/0. A step occurs again only after a fresh 4-cycle debounce.
- Rebuild without the macro, `vblank`=0 constant, hold left -> pulses every 10 cycles regardless of `vblank`.

Source files
------------

// File: rtl/player_move_ctrl_pkg.sv
// rtl/player_move_ctrl_pkg.sv - direction codes, FSM states and the sticky arbiter shared with the player block
package player_move_ctrl_pkg;

    localparam logic [1:0] DIR_LEFT  = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARM     = 2'b01,
        ST_WAIT_VB = 2'b10,
        ST_STEP    = 2'b11
    } state_t;

    // i_btns is indexed by direction code; with nothing held the current grant is kept
    function automatic logic [1:0] arbitrate(input logic [3:0] i_btns,
                                             input logic [1:0] i_cur,
                                             input logic       i_sticky);
        logic [1:0] w_sel;
        w_sel = i_cur;
        if (i_sticky && i_btns[i_cur]) w_sel = i_cur;
        else if (i_btns[DIR_LEFT])     w_sel = DIR_LEFT;
        else if (i_btns[DIR_RIGHT])    w_sel = DIR_RIGHT;
        else if (i_btns[DIR_UP])       w_sel = DIR_UP;
        else if (i_btns[DIR_DOWN])     w_sel = DIR_DOWN;
        return w_sel;
    endfunction

endpackage

// File: rtl/player_move_ctrl_debounce.sv
// rtl/player_move_ctrl_debounce.sv - btn_debounce: level flips after DB_COUNT consecutive disagreeing cycles
module btn_debounce
    import player_move_ctrl_pkg::*;
#(
    parameter int DB_COUNT = 250000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level
);

    localparam logic [19:0] DB_MAX = 20'(DB_COUNT - 1);

    logic [19:0] r_cnt;
    logic        r_level;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (i_raw == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == DB_MAX) begin
            r_level <= ~r_level;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + 20'd1;
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/player_move_ctrl.sv
// rtl/player_move_ctrl.sv - player step sequencer: debounce, sticky arbitration, repeat timer, vblank-aligned steps
// Optional macro MOVE_VBLANK_SYNC_EN: when defined, steps wait for vblank; otherwise vblank is ignored.
module player_move_ctrl
    import player_move_ctrl_pkg::*;
#(
    parameter int DB_COUNT = 250000,
    parameter int STEP_DIV = 100000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn_left,
    input  logic       i_btn_right,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    input  logic       i_vblank,
    output logic       o_move_step,
    output logic [1:0] o_move_dir,
    output logic       o_moving
);

    localparam logic [19:0] STEP_MAX = 20'(STEP_DIV - 1);

    logic [3:0]  w_raw;
    logic [3:0]  w_btn;
    logic        w_any;
    logic        w_vb;
    state_t      r_state, w_next;
    logic [19:0] r_timer, w_timer_next;
    logic [1:0]  r_dir, w_dir_next;
    logic        r_move_step;
    logic        r_moving;

    assign w_raw = {i_btn_down, i_btn_up, i_btn_right, i_btn_left};

    for (genvar g = 0; g < 4; g++) begin : g_db
        btn_debounce #(.DB_COUNT(DB_COUNT)) u_db (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_raw   (w_raw[g]),
            .o_level (w_btn[g])
        );
    end

    assign w_any = |w_btn;

`ifdef MOVE_VBLANK_SYNC_EN
    assign w_vb = i_vblank;
`else
    assign w_vb = i_vblank | 1'b1;
`endif

    always_comb begin
        w_next       = r_state;
        w_dir_next   = r_dir;
        w_timer_next = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_dir_next = arbitrate(w_btn, r_dir, 1'b0);
                    w_next     = ST_WAIT_VB;
                end
            end
            ST_WAIT_VB: begin
                if (!w_any)    w_next = ST_IDLE;
                else if (w_vb) w_next = ST_STEP;
            end
            ST_STEP: begin
                // direction for the next step is chosen while this one is issued
                if (!w_any) begin
                    w_next = ST_IDLE;
                end else begin
                    w_dir_next = arbitrate(w_btn, r_dir, 1'b1);
                    w_next     = ST_ARM;
                end
            end
            ST_ARM: begin
                if (!w_any)                  w_next = ST_IDLE;
                else if (r_timer == STEP_MAX) w_next = ST_WAIT_VB;
                else                          w_timer_next = r_timer + 20'd1;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_dir       <= DIR_LEFT;
            r_move_step <= 1'b0;
            r_moving    <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_timer     <= w_timer_next;
            r_dir       <= w_dir_next;
            r_move_step <= (w_next == ST_STEP);
            r_moving    <= (w_next != ST_IDLE);
        end
    end

    assign o_move_step = r_move_step;
    assign o_move_dir  = r_dir;
    assign o_moving    = r_moving;

endmodule

// File: tb/tb_player_move_ctrl.sv
// tb/tb_player_move_ctrl.sv - directed bench for player_move_ctrl (DB_COUNT=4, STEP_DIV=8), both MOVE_VBLANK_SYNC_EN builds
module tb_player_move_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bl = 1'b0, br = 1'b0, bu = 1'b0, bd = 1'b0;
    logic       vb = 1'b0;
    logic       step;
    logic [1:0] dir;
    logic       moving;
    int         total = 0;
    int         bad = 0;

    player_move_ctrl #(.DB_COUNT(4), .STEP_DIV(8)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_btn_left  (bl),
        .i_btn_right (br),
        .i_btn_up    (bu),
        .i_btn_down  (bd),
        .i_vblank    (vb),
        .o_move_step (step),
        .o_move_dir  (dir),
        .o_moving    (moving)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input logic [1:0] d, input logic v);
        case (d)
            2'b00:   bl = v;
            2'b01:   br = v;
            2'b10:   bu = v;
            default: bd = v;
        endcase
    endtask

    // hold one button from idle: WAIT_VB at k=5, steps at k=6,16,26
    task automatic run_hold(input string tag, input logic [1:0] d, input logic vbl);
        vb = vbl;
        set_btn(d, 1'b1);
        for (int k = 1; k <= 30; k++) begin
            cyc(1);
            chk({tag, "_step"}, step, (k == 6 || k == 16 || k == 26));
            if (k >= 5) chk({tag, "_dir"}, dir, d);
        end
        set_btn(d, 1'b0);
        cyc(6);
        chk({tag, "_idle"}, moving, 1'b0);
    endtask

    initial begin
        int nsteps;
        int w;
        logic found;

        cyc(2);
        chk("rst_step", step, 1'b0);
        chk("rst_dir", dir, 2'b00);
        chk("rst_moving", moving, 1'b0);
        rst = 1'b0;

        // bouncing left: 1,1,0,0 then held; only the stable run counts
        bl = 1'b1; cyc(2);
        bl = 1'b0; cyc(2);
        chk("bounce_moving", moving, 1'b0);
        bl = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cyc(1);
            chk("bounce_hold", moving, 1'b0);
        end
        cyc(1);
        chk("bounce_rise", moving, 1'b1);
        chk("bounce_dir", dir, 2'b00);
        bl = 1'b0;
        cyc(4);
        chk("bounce_rel_hold", moving, 1'b1);
        cyc(1);
        chk("bounce_rel_fall", moving, 1'b0);

        run_hold("right_vb1", 2'b01, 1'b1);

`ifdef MOVE_VBLANK_SYNC_EN
        // up with vblank high 2 of every 50 cycles
        nsteps = 0;
        bu = 1'b1;
        for (int c = 0; c < 150; c++) begin
            vb = ((c % 50) == 40) || ((c % 50) == 41);
            cyc(1);
            if (step) begin
                nsteps++;
                chk("vb_align", vb, 1'b1);
            end
        end
        chk("vb_count", nsteps, 3);
        bu = 1'b0; vb = 1'b0;
        cyc(6);
        chk("vb_idle", moving, 1'b0);
`endif

        // sticky grant: down keeps priority over a later left
        vb = 1'b1;
        bd = 1'b1;
        cyc(8);
        chk("sticky_moving", moving, 1'b1);
        chk("sticky_dir0", dir, 2'b11);
        bl = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            chk("sticky_dir", dir, 2'b11);
        end
        bd = 1'b0;
        cyc(30);
        chk("sticky_switch", dir, 2'b00);
        chk("sticky_still", moving, 1'b1);

`ifdef MOVE_VBLANK_SYNC_EN
        // park in WAIT_VB, then release: no step, moving drops
        vb = 1'b0;
        cyc(12);
        bl = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            cyc(1);
            chk("wvb_rel_step", step, 1'b0);
            chk("wvb_rel_moving", moving, (i < 5));
        end
`else
        bl = 1'b0;
        cyc(6);
        chk("rel_idle", moving, 1'b0);
`endif

        // reset during ARM with right held
        vb = 1'b1;
        br = 1'b1;
        found = 1'b0;
        w = 0;
        while (!found && w < 40) begin
            cyc(1);
            w++;
            if (step) found = 1'b1;
        end
        chk("arm_found_step", found, 1'b1);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        chk("mid_rst_step", step, 1'b0);
        chk("mid_rst_dir", dir, 2'b00);
        chk("mid_rst_moving", moving, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cyc(1);
            chk("post_rst_db", moving, 1'b0);
            chk("post_rst_nostep", step, 1'b0);
        end
        cyc(1);
        chk("post_rst_moving", moving, 1'b1);
        cyc(1);
        chk("post_rst_step", step, 1'b1);
        chk("post_rst_dir", dir, 2'b01);
        br = 1'b0;
        cyc(6);
        chk("post_rst_idle", moving, 1'b0);

`ifndef MOVE_VBLANK_SYNC_EN
        run_hold("nomacro_left", 2'b00, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
